// File: rtl/vdb_vga_pkg.sv
// Shared types and limits for the VGA transmit timing generator.
// The axis helper sums one axis's active span and porch/sync widths into a period.
package vdb_vga_pkg;

  localparam int unsigned MAX_PIXELS = 1024;
  localparam int unsigned MAX_LINES  = 768;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] front_porch;
    logic [7:0] sync;
    logic [7:0] back_porch;
  } sync_t;

  function automatic int unsigned axis_total(input int unsigned act, input sync_t s);
    return act + int'(s.front_porch) + int'(s.sync) + int'(s.back_porch);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// One timing axis: counter over active, front porch, sync and back porch.
// A region decode for the current count is provided. clr_i parks the count at 0.
module vga_sync_counter
  import vdb_vga_pkg::*;
#(
  parameter int unsigned ACT  = 640,
  parameter int unsigned FP   = 16,
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        cnt_en_i,
  output logic [10:0] count_o,
  output logic        active_o,
  output logic        sync_o,
  output logic        wrap_o
);

  localparam sync_t PORCH = '{front_porch: 8'(FP), sync: 8'(SYNC), back_porch: 8'(BP)};
  localparam int unsigned TOT = axis_total(ACT, PORCH);

  localparam logic [10:0] LAST     = 11'(TOT - 1);
  localparam logic [10:0] ACT_END  = 11'(ACT);
  localparam logic [10:0] SYNC_BEG = 11'(ACT + int'(PORCH.front_porch));
  localparam logic [10:0] SYNC_END = 11'(ACT + int'(PORCH.front_porch) + int'(PORCH.sync));

  logic [10:0] count_q;
  logic [10:0] count_d;

  assign wrap_o = cnt_en_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i || wrap_o) begin
      count_d = '0;
    end else if (cnt_en_i) begin
      count_d = count_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign active_o = (count_q < ACT_END);
  assign sync_o   = (count_q >= SYNC_BEG) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_tx_timing_gen.sv
// VGA transmit timing: requests pixels from a same-cycle source and registers
// video, syncs and status pulses one cycle behind the counters.
module vga_tx_timing_gen
  import vdb_vga_pkg::*;
#(
  parameter int unsigned HOR_ACT   = 640,
  parameter int unsigned HOR_FP    = 16,
  parameter int unsigned HOR_SYNC  = 96,
  parameter int unsigned HOR_BP    = 48,
  parameter int unsigned VERT_ACT  = 480,
  parameter int unsigned VERT_FP   = 11,
  parameter int unsigned VERT_SYNC = 2,
  parameter int unsigned VERT_BP   = 31
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic        pixel_req_o,
  output logic [9:0]  pixel_x_o,
  output logic [9:0]  pixel_y_o,
  input  logic        pixel_valid_i,
  input  logic [23:0] pixel_rgb_i,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start_o,
  output logic        underflow_o
);

  if (HOR_ACT == 0 || HOR_ACT > MAX_PIXELS ||
      HOR_FP == 0 || HOR_FP > 255 || HOR_SYNC == 0 || HOR_SYNC > 255 ||
      HOR_BP == 0 || HOR_BP > 255) begin : g_bad_hor
    $fatal(1, "vga_tx_timing_gen: horizontal timing parameter out of range");
  end

  if (VERT_ACT == 0 || VERT_ACT > MAX_LINES ||
      VERT_FP == 0 || VERT_FP > 255 || VERT_SYNC == 0 || VERT_SYNC > 255 ||
      VERT_BP == 0 || VERT_BP > 255) begin : g_bad_vert
    $fatal(1, "vga_tx_timing_gen: vertical timing parameter out of range");
  end

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_active;
  logic        h_sync;
  logic        h_wrap;
  logic        v_active;
  logic        v_sync;
  logic        v_wrap_unused;
  logic        unused_bits;

  vga_sync_counter #(
    .ACT  (HOR_ACT),
    .FP   (HOR_FP),
    .SYNC (HOR_SYNC),
    .BP   (HOR_BP)
  ) u_h_cnt (
    .clk      (pixel_clk),
    .rst_n    (rst_n),
    .clr_i    (!en_i),
    .cnt_en_i (en_i),
    .count_o  (h_cnt),
    .active_o (h_active),
    .sync_o   (h_sync),
    .wrap_o   (h_wrap)
  );

  // Lines advance only on the horizontal wrap, so both wraps land on (0,0) together.
  vga_sync_counter #(
    .ACT  (VERT_ACT),
    .FP   (VERT_FP),
    .SYNC (VERT_SYNC),
    .BP   (VERT_BP)
  ) u_v_cnt (
    .clk      (pixel_clk),
    .rst_n    (rst_n),
    .clr_i    (!en_i),
    .cnt_en_i (h_wrap),
    .count_o  (v_cnt),
    .active_o (v_active),
    .sync_o   (v_sync),
    .wrap_o   (v_wrap_unused)
  );

  assign unused_bits = ^{h_cnt[10], v_cnt[10], v_wrap_unused};

  assign pixel_req_o = en_i && h_active && v_active;
  assign pixel_x_o   = pixel_req_o ? h_cnt[9:0] : 10'd0;
  assign pixel_y_o   = pixel_req_o ? v_cnt[9:0] : 10'd0;

  rgb_t rgb_q;
  rgb_t rgb_d;
  logic hsync_q;
  logic hsync_d;
  logic vsync_q;
  logic vsync_d;
  logic frame_start_q;
  logic frame_start_d;
  logic underflow_q;
  logic underflow_d;

  // Everything below is decoded from the same counter stage as the pixel request.
  always_comb begin
    rgb_d         = '0;
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;
    if (en_i) begin
      hsync_d       = !h_sync;
      vsync_d       = !v_sync;
      frame_start_d = (h_cnt == 11'd0) && (v_cnt == 11'd0);
      if (pixel_req_o) begin
        if (pixel_valid_i) begin
          rgb_d = rgb_t'(pixel_rgb_i);
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign r             = rgb_q.r;
  assign g             = rgb_q.g;
  assign b             = rgb_q.b;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign frame_start_o = frame_start_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_vga_tx_timing_gen.sv
// Directed bench for vga_tx_timing_gen on a 17x8 timing (8/2/3/4, 4/1/2/1).
// Expected values come from the timing table: state s = h + 17*v, one per cycle.
module tb_vga_tx_timing_gen;

  localparam int H_TOT = 17;
  localparam int F_TOT = 136;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic        pixel_req_o;
  logic [9:0]  pixel_x_o;
  logic [9:0]  pixel_y_o;
  logic        pixel_valid_i;
  logic [23:0] pixel_rgb_i;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        hsync;
  logic        vsync;
  logic        frame_start_o;
  logic        underflow_o;

  int tests_run    = 0;
  int tests_failed = 0;

  int s;
  int cyc;
  int last_fs_cyc;
  int n_req;
  int n_hs;
  int n_vs;
  int n_uf;
  int n_fs;

  logic [23:0] exp_rgb;
  logic        exp_hs;
  logic        exp_vs;
  logic        exp_fs;
  logic        exp_uf;
  logic        obs_hs_prev;
  logic        obs_vs_prev;

  vga_tx_timing_gen #(
    .HOR_ACT   (8),
    .HOR_FP    (2),
    .HOR_SYNC  (3),
    .HOR_BP    (4),
    .VERT_ACT  (4),
    .VERT_FP   (1),
    .VERT_SYNC (2),
    .VERT_BP   (1)
  ) dut (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .pixel_req_o   (pixel_req_o),
    .pixel_x_o     (pixel_x_o),
    .pixel_y_o     (pixel_y_o),
    .pixel_valid_i (pixel_valid_i),
    .pixel_rgb_i   (pixel_rgb_i),
    .r             (r),
    .g             (g),
    .b             (b),
    .hsync         (hsync),
    .vsync         (vsync),
    .frame_start_o (frame_start_o),
    .underflow_o   (underflow_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, s=%0d)", tag, got, exp, cyc, s);
    end
  endtask

  task automatic expect_reset_state();
    exp_rgb     = 24'd0;
    exp_hs      = 1'b1;
    exp_vs      = 1'b1;
    exp_fs      = 1'b0;
    exp_uf      = 1'b0;
    obs_hs_prev = 1'b1;
    obs_vs_prev = 1'b1;
    last_fs_cyc = -1;
  endtask

  task automatic clear_stats();
    n_req = 0;
    n_hs  = 0;
    n_vs  = 0;
    n_uf  = 0;
    n_fs  = 0;
  endtask

  // Drive at edge+1, sample at edge+2; registered outputs reflect the previous state.
  task automatic run_cycle(input logic en, input logic valid);
    logic [23:0] pix;
    int          h;
    int          v;
    logic        req;
    pix           = 24'($urandom());
    en_i          = en;
    pixel_valid_i = valid;
    pixel_rgb_i   = pix;
    #1;
    h   = s % H_TOT;
    v   = s / H_TOT;
    req = en && (h < 8) && (v < 4);
    check("req", 32'(pixel_req_o), 32'(req));
    check("x", 32'(pixel_x_o), req ? 32'(h) : 32'd0);
    check("y", 32'(pixel_y_o), req ? 32'(v) : 32'd0);
    check("rgb", {8'd0, r, g, b}, {8'd0, exp_rgb});
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
    check("frame_start", 32'(frame_start_o), 32'(exp_fs));
    check("underflow", 32'(underflow_o), 32'(exp_uf));
    n_req += int'(pixel_req_o);
    n_hs  += int'(!hsync);
    n_vs  += int'(!vsync);
    n_uf  += int'(underflow_o);
    n_fs  += int'(frame_start_o);
    if (obs_hs_prev && !hsync) check("hs_start", 32'(h), 32'd11);
    if (obs_vs_prev && !vsync) check("vs_start", 32'(s), 32'd86);
    if (frame_start_o) begin
      if (last_fs_cyc >= 0) check("frame_period", 32'(cyc - last_fs_cyc), 32'(F_TOT));
      last_fs_cyc = cyc;
    end
    exp_rgb     = (req && valid) ? pix : 24'd0;
    exp_hs      = !(en && h >= 10 && h < 13);
    exp_vs      = !(en && v >= 5 && v < 7);
    exp_fs      = en && (s == 0);
    exp_uf      = req && !valid;
    obs_hs_prev = hsync;
    obs_vs_prev = vsync;
    if (!en) last_fs_cyc = -1;
    @(posedge pixel_clk);
    #1;
    cyc++;
    s = en ? (s + 1) % F_TOT : 0;
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < F_TOT && s != target; i++) run_cycle(1'b1, 1'b1);
    check("reach_state", 32'(s), 32'(target));
  endtask

  initial begin
    rst_n         = 1'b0;
    en_i          = 1'b1;
    pixel_valid_i = 1'b1;
    pixel_rgb_i   = 24'd0;
    s             = 0;
    cyc           = 0;
    expect_reset_state();
    clear_stats();
    repeat (3) @(posedge pixel_clk);
    #1;

    $display("[TB] reset held: checking reset outputs");
    check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_frame_start", 32'(frame_start_o), 32'd0);
    check("rst_underflow", 32'(underflow_o), 32'd0);

    $display("[TB] reset release, one full frame");
    rst_n = 1'b1;
    s     = 0;
    clear_stats();
    for (int i = 0; i < F_TOT; i++) run_cycle(1'b1, 1'b1);
    check("frame_requests", 32'(n_req), 32'd32);
    check("frame_hs_low", 32'(n_hs), 32'd24);
    check("frame_vs_low", 32'(n_vs), 32'd34);
    check("frame_fs_count", 32'(n_fs), 32'd1);

    $display("[TB] pixel_valid_i dropped at x=3 y=1");
    run_until(20);
    clear_stats();
    run_cycle(1'b1, 1'b0);
    for (int i = 1; i < F_TOT; i++) run_cycle(1'b1, 1'b1);
    check("uf_count", 32'(n_uf), 32'd1);
    check("uf_requests", 32'(n_req), 32'd32);
    check("uf_hs_low", 32'(n_hs), 32'd24);
    check("uf_vs_low", 32'(n_vs), 32'd34);

    $display("[TB] en_i dropped at x=5 y=2 for 4 cycles");
    run_until(39);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b1);

    $display("[TB] en_i dropped inside hsync for 2 cycles");
    run_until(11);
    for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b1);

    $display("[TB] rst_n asserted mid-hsync");
    run_until(29);
    check("hs_before_rst", 32'(hsync), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_hsync", 32'(hsync), 32'd1);
    check("async_rst_vsync", 32'(vsync), 32'd1);
    check("async_rst_rgb", {8'd0, r, g, b}, 32'd0);
    @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
    s     = 0;
    expect_reset_state();
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_tx_timing_gen.md
VGA_TX_TIMING_GEN -- requirements
Module: vga_tx_timing_gen

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- HOR_ACT, 640, active pixels per line (1..1024)
- HOR_FP, 16, horizontal front porch in pixels (1..255)
- HOR_SYNC, 96, hsync width in pixels (1..255)
- HOR_BP, 48, horizontal back porch in pixels (1..255)
- VERT_ACT, 480, active lines (1..768)
- VERT_FP, 11, vertical front porch in lines (1..255)
- VERT_SYNC, 2, vsync width in lines (1..255)
- VERT_BP, 31, vertical back porch in lines (1..255)

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- pixel_clk, in, 1, pixel clock, the only clock
- rst_n, in, 1, asynchronous active-low reset
- en_i, in, 1, timing enable
- pixel_req_o, out, 1, pixel wanted this cycle
- pixel_x_o, out, 10, column of the requested pixel
- pixel_y_o, out, 10, line of the requested pixel
- pixel_valid_i, in, 1, source has pixel_rgb_i ready
- pixel_rgb_i, in, 24, requested pixel as {r,g,b}
- r, out, 8, red video
- g, out, 8, green video
- b, out, 8, blue video
- hsync, out, 1, horizontal sync, active low
- vsync, out, 1, vertical sync, active low
- frame_start_o, out, 1, one-cycle pulse at the first pixel of a frame
- underflow_o, out, 1, one-cycle pulse on a missed pixel

Function
REQ-003 SHALL keep a horizontal counter h_cnt (11 bit) over 0..H_TOT-1, with H_TOT = HOR_ACT+HOR_FP+HOR_SYNC+HOR_BP, and wrap to 0 after H_TOT-1.
REQ-004 SHALL keep a vertical counter v_cnt (11 bit) over 0..V_TOT-1, incrementing only when h_cnt wraps and wrapping to 0 after V_TOT-1.
REQ-005 Per-line region order SHALL be: active [0, HOR_ACT), front porch, sync, back porch. Vertical SHALL use the same order.
REQ-006 pixel_req_o SHALL be high (combinational from the counters) iff en_i, h_cnt<HOR_ACT and v_cnt<VERT_ACT. Then pixel_x_o=h_cnt and pixel_y_o=v_cnt; otherwise both are 0.
REQ-007 The source SHALL respond in the same cycle. The block samples pixel_rgb_i when pixel_req_o and pixel_valid_i are both high.
REQ-008 r,g,b SHALL be registered with a latency of 1: the sampled pixel appears one cycle after the request, and is 0 outside active video.
REQ-009 If pixel_req_o is high and pixel_valid_i is low, r,g,b SHALL be 0 on the next cycle and underflow_o SHALL pulse on that cycle. Counters never stall.
REQ-010 hsync and vsync SHALL be registered from the same counter stage as r,g,b (latency 1):
- hsync low iff h_cnt is in [HOR_ACT+HOR_FP, HOR_ACT+HOR_FP+HOR_SYNC)
- vsync low iff v_cnt is in the corresponding vertical window, for whole lines
REQ-011 frame_start_o SHALL pulse with latency 1, aligned with the first pixel (h_cnt=0, v_cnt=0), only while en_i is high.
REQ-012 While en_i is low, the block SHALL:
- force counters to 0
- hold pixel_req_o low
- drive r,g,b=0, hsync=1, vsync=1, no pulses
REQ-013 When en_i rises, the next cycle SHALL present h_cnt=0, v_cnt=0 (a fresh frame). Deasserting en_i mid-frame SHALL abort the frame immediately.
REQ-014 Simultaneous horizontal and vertical wrap SHALL produce h_cnt=0, v_cnt=0 with no skipped or duplicated line.

Reset
REQ-015 On rst_n low, asynchronously:
- h_cnt=0, v_cnt=0
- r,g,b=0
- hsync=1, vsync=1
- frame_start_o=0, underflow_o=0
REQ-016 After rst_n deasserts with en_i high, the first rising edge SHALL start pixel (0,0). A reset asserted mid-frame SHALL take effect without waiting for a frame boundary.

Structure
REQ-017 Package vdb_vga_pkg SHALL hold:
- rgb_t (packed 3x8 bit)
- sync_t (front_porch, sync, back_porch, each 8 bit)
- MAX_PIXELS=1024, MAX_LINES=768
REQ-018 Parameter ranges (REQ-001) SHALL be checked at elaboration and fail fatally when violated.
REQ-019 Sub-module vga_sync_counter SHALL provide one parameterised axis counter with region decode: count enable in; count, active, sync and wrap out. It is instanced twice, horizontal and vertical (enable = horizontal wrap).

Verification
Small timing for all scenarios: HOR 8/2/3/4 (H_TOT=17), VERT 4/1/2/1 (V_TOT=8).
REQ-020 Reset release with en_i=1 and pixel_valid_i=1 -> cycle 0: pixel_req_o=1, x=0, y=0. Cycle 1: rgb equals the cycle-0 pixel_rgb_i and frame_start_o=1.
REQ-021 Run one frame -> 32 requests; hsync low exactly 3 cycles per line, starting 11 cycles after each line start; vsync low for 34 cycles (2 lines); frame period 136 cycles.
REQ-022 Drop pixel_valid_i at x=3, y=1 -> next cycle rgb=0 and one underflow_o pulse; line and frame timing unchanged.
REQ-023 Drop en_i at x=5, y=2 for 4 cycles, then raise it -> outputs blank with syncs high while low; one cycle after the rise, x=0, y=0 and frame_start_o=1.
REQ-024 Assert rst_n low mid-hsync -> hsync=1 immediately (asynchronously); after release, timing restarts at (0,0).
